// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
// Holds the access-mode encodings, the MMIO trigger address and the FSM state
// enum, plus helpers that classify a request mode.
package mem_pkg;

    localparam logic [2:0] MODE_WORD  = 3'b001;
    localparam logic [2:0] MODE_HALF  = 3'b010;
    localparam logic [2:0] MODE_BYTE  = 3'b011;
    localparam logic [2:0] MODE_UHALF = 3'b100;
    localparam logic [2:0] MODE_UBYTE = 3'b101;

    localparam logic [31:0] MMIO_TRIGGER_ADDR = 32'h0000_0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode == MODE_WORD) || (mode == MODE_HALF) || (mode == MODE_BYTE) ||
               (mode == MODE_UHALF) || (mode == MODE_UBYTE);
    endfunction

    // Index of the final byte beat for a legal, non-MMIO access.
    function automatic logic [1:0] mode_last_beat(input logic [2:0] mode);
        case (mode)
            MODE_WORD:              return 2'd3;
            MODE_HALF, MODE_UHALF:  return 2'd1;
            default:                return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of assembled load data.
// Ports:
//   mode - access mode of the load
//   raw  - little-endian assembled bytes (byte 0 in bits 7:0)
//   ext  - extended result; word mode (and anything else) passes raw through
module load_extend
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] ext
);

    always_comb begin
        ext = raw;
        case (mode)
            MODE_HALF:  ext = {{(WIDTH-16){raw[15]}}, raw[15:0]};
            MODE_BYTE:  ext = {{(WIDTH-8){raw[7]}}, raw[7:0]};
            MODE_UHALF: ext = {{(WIDTH-16){1'b0}}, raw[15:0]};
            MODE_UBYTE: ext = {{(WIDTH-8){1'b0}}, raw[7:0]};
            default:    ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns one pipeline load/store request into a sequence
// of single-byte memory beats (or one word beat inside the MMIO window) and
// returns a one-cycle response with extended load data.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   req_valid/req_ready             - request handshake (ready only in IDLE)
//   req_we, req_mode, req_addr, req_wdata - request payload
//   rsp_valid, rsp_rdata, rsp_err   - single-cycle response
//   mem_addr, mem_wd, mem_we, mem_mode - data memory command
//   mem_rd                          - combinational data memory read data
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_mode,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    output logic             mem_we,
    output logic [2:0]       mem_mode,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int NB = 4;
    localparam logic [WIDTH-1:0] MMIO_ADDR_W = WIDTH'(MMIO_TRIGGER_ADDR);

    state_t           state_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] load_reg;
    logic [WIDTH-1:0] load_next;
    logic [WIDTH-1:0] load_ext;
    logic [WIDTH-1:0] rsp_rdata_reg;
    logic             we_reg;
    logic             mmio_reg;
    logic             rsp_valid_reg;
    logic             rsp_err_reg;
    logic [2:0]       mode_reg;
    logic [1:0]       beat_reg;
    logic [1:0]       last_beat_reg;
    logic             in_access;
    logic             req_is_mmio;
    logic [7:0]       wdata_byte [NB];
    logic [7:0]       load_byte  [NB];

    // Per-byte views: the store byte for each beat, and the load register with
    // the current beat's byte replaced by the memory read data.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
            assign wdata_byte[gi] = wdata_reg[8*gi +: 8];
            assign load_byte[gi]  = (beat_reg == 2'(gi)) ? mem_rd[7:0] : load_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        load_next = '0;
        if (mmio_reg) begin
            load_next = mem_rd;
        end else begin
            for (int i = 0; i < NB; i++) begin
                load_next[8*i +: 8] = load_byte[i];
            end
        end
    end

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .mode (mode_reg),
        .raw  (load_next),
        .ext  (load_ext)
    );

    assign in_access   = (state_reg == ACCESS);
    assign req_ready   = (state_reg == IDLE);
    assign req_is_mmio = (req_addr[WIDTH-1:2] == MMIO_ADDR_W[WIDTH-1:2]);

    assign mem_addr = in_access ? (addr_reg + WIDTH'(beat_reg)) : '0;
    assign mem_mode = in_access ? (mmio_reg ? MODE_WORD : MODE_BYTE) : 3'b000;
    assign mem_wd   = in_access ? (mmio_reg ? wdata_reg : WIDTH'(wdata_byte[beat_reg])) : '0;
    // Gated by rst_n so a reset landing mid-store cannot commit the current beat.
    assign mem_we   = in_access & we_reg & rst_n;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            load_reg      <= '0;
            rsp_rdata_reg <= '0;
            we_reg        <= 1'b0;
            mmio_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            mode_reg      <= 3'b000;
            beat_reg      <= 2'd0;
            last_beat_reg <= 2'd0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        we_reg        <= req_we;
                        mode_reg      <= req_mode;
                        mmio_reg      <= req_is_mmio;
                        last_beat_reg <= req_is_mmio ? 2'd0 : mode_last_beat(req_mode);
                        beat_reg      <= 2'd0;
                        load_reg      <= '0;
                        if (!mode_legal(req_mode)) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                        end else begin
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_reg) begin
                        load_reg <= load_next;
                    end
                    if (beat_reg == last_beat_reg) begin
                        // Response data is built from load_next so the final
                        // beat's byte is included without an extra cycle.
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= we_reg ? '0 : (mmio_reg ? load_next : load_ext);
                    end else begin
                        beat_reg <= beat_reg + 2'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array data memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_rd;

    mem_access_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_mode  (req_mode),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_mode  (mem_mode),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  mode;
        logic        we;
        logic [31:0] wd;
        bit          chk_wd;
    } beat_t;

    rsp_t  sb_q[$];
    beat_t beat_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stray_we = 0;
    bit mem_init = 1'b0;

    logic [7:0] dmem    [512];
    logic [7:0] ref_mem [512];

    function automatic logic [8:0] idx(input logic [31:0] a);
        return 9'(a & 32'h1FF);
    endfunction

    // Data memory: word reads for mode 001, otherwise a zero-extended byte.
    assign mem_rd = (mem_mode == 3'b001) ?
        {dmem[idx(mem_addr + 32'd3)], dmem[idx(mem_addr + 32'd2)],
         dmem[idx(mem_addr + 32'd1)], dmem[idx(mem_addr)]} :
        {24'h0, dmem[idx(mem_addr)]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < 512; i++) dmem[i] <= ref_mem[i];
        end else if (mem_we) begin
            if (mem_mode == 3'b001) begin
                for (int k = 0; k < 4; k++) dmem[idx(mem_addr + 32'(k))] <= mem_wd[8*k +: 8];
            end else begin
                dmem[idx(mem_addr)] <= mem_wd[7:0];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one beat popped per cycle after an accept, one response popped per rsp_valid.
    always @(negedge clk) begin
        beat_t b;
        rsp_t  e;
        if (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            chk("beat_addr", 64'(mem_addr), 64'(b.addr));
            chk("beat_ctl", {mem_mode, mem_we, (b.chk_wd ? mem_wd : 32'h0)},
                            {b.mode, b.we, (b.chk_wd ? b.wd : 32'h0)});
            $display("beat addr=%h mode=%b we=%b wd=%h", mem_addr, mem_mode, mem_we, mem_wd);
        end else if (mem_we !== 1'b0) begin
            stray_we++;
        end
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'h0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_data", {31'h0, rsp_err, rsp_rdata}, {31'h0, e.err, e.rdata});
                chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                $display("rsp rdata=%h err=%b lat=%0d", rsp_rdata, rsp_err, cyc - e.acc);
            end
        end
    end

    // Drive one request; the reference model computes beats and the response
    // from the byte-level rules. abort_after >= 0 pushes only that many beats
    // and no response (the caller resets the unit mid-access).
    task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input int abort_after,
                         input bit use_want, input logic [31:0] want);
        int          n;
        int          waited;
        int          acc;
        bit          legal;
        bit          mmio;
        logic [31:0] v;
        logic [31:0] a;
        rsp_t        r;
        beat_t       b;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            chk("handshake_timeout", 64'(req_ready), 64'h1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk);
        legal = (mode >= 3'd1) && (mode <= 3'd5);
        mmio  = (addr >> 2) == (32'h100 >> 2);
        v = 32'h0;
        r.err = 1'b0;
        r.acc = acc;
        if (!legal) begin
            r.err = 1'b1;
            r.lat = 1;
            r.rdata = 32'h0;
        end else if (mmio) begin
            b.addr = addr; b.mode = 3'b001; b.we = we; b.wd = wdata; b.chk_wd = 1'b0;
            beat_q.push_back(b);
            for (int k = 0; k < 4; k++) begin
                a = addr + 32'(k);
                if (we) ref_mem[idx(a)] = wdata[8*k +: 8];
                else v[8*k +: 8] = ref_mem[idx(a)];
            end
            r.lat = 2;
            r.rdata = we ? 32'h0 : v;
        end else begin
            n = (mode == 3'd1) ? 4 : ((mode == 3'd2 || mode == 3'd4) ? 2 : 1);
            if (abort_after >= 0) n = abort_after;
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                b.addr = a; b.mode = 3'b011; b.we = we; b.wd = {24'h0, wdata[8*k +: 8]}; b.chk_wd = 1'b1;
                beat_q.push_back(b);
                if (we) ref_mem[idx(a)] = wdata[8*k +: 8];
                else v[8*k +: 8] = ref_mem[idx(a)];
            end
            r.lat = n + 1;
            case (mode)
                3'd2:    r.rdata = 32'($signed(v[15:0]));
                3'd3:    r.rdata = 32'($signed(v[7:0]));
                3'd4:    r.rdata = {16'h0, v[15:0]};
                3'd5:    r.rdata = {24'h0, v[7:0]};
                default: r.rdata = v;
            endcase
            if (we) r.rdata = 32'h0;
        end
        if (use_want) r.rdata = want;
        if (abort_after < 0) sb_q.push_back(r);
        $display("req we=%b mode=%b addr=%h wdata=%h exp=%h err=%b", we, mode, addr, wdata, r.rdata, r.err);
        // Garbage on the request inputs while busy must be ignored.
        #1;
        req_we    = 1'($urandom_range(0, 1));
        req_mode  = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] wd;
        logic [15:0] old_hi;
        int          w;
        int          mism;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_mode = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom_range(0, 255));
        ref_mem[9'h012] = 8'h34;
        ref_mem[9'h013] = 8'h85;
        ref_mem[9'h100] = 8'h01;
        ref_mem[9'h101] = 8'h00;
        ref_mem[9'h102] = 8'h00;
        ref_mem[9'h103] = 8'h00;
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'h1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_rsp_err", 64'(rsp_err), 64'h0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("reset_mem_we", 64'(mem_we), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(1'b0, 3'b010, 32'h12, $urandom, -1, 1'b1, 32'hFFFF8534);
        issue(1'b0, 3'b100, 32'h12, $urandom, -1, 1'b1, 32'h00008534);
        issue(1'b1, 3'b001, 32'h10, 32'hA1B2C3D4, -1, 1'b0, 32'h0);
        repeat (6) @(negedge clk);
        chk("store_word_mem", 64'({dmem[9'h013], dmem[9'h012], dmem[9'h011], dmem[9'h010]}), 64'hA1B2C3D4);
        issue(1'b0, 3'b011, 32'hFFFFFFFF, $urandom, -1, 1'b0, 32'h0);
        issue(1'b0, 3'b001, 32'hFFFFFFFE, $urandom, -1, 1'b0, 32'h0);
        issue(1'b0, 3'b001, 32'h100, $urandom, -1, 1'b1, 32'h00000001);
        issue(1'b0, 3'b111, 32'h20, $urandom, -1, 1'b0, 32'h0);
        issue(1'b1, 3'b111, 32'h24, $urandom, -1, 1'b0, 32'h0);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, -1, 1'b0, 32'h0);
        end

        // Reset during beat 2 of a store word at 0x20.
        w = 0;
        while (sb_q.size() > 0 && w < 20) begin @(negedge clk); w++; end
        wd = $urandom;
        old_hi = {ref_mem[9'h023], ref_mem[9'h022]};
        issue(1'b1, 3'b001, 32'h20, wd, 2, 1'b0, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", 64'(req_ready), 64'h1);
        chk("abort_no_rsp", 64'(rsp_valid), 64'h0);
        chk("abort_bytes01", 64'({dmem[9'h021], dmem[9'h020]}), 64'(wd[15:0]));
        chk("abort_bytes23", 64'({dmem[9'h023], dmem[9'h022]}), 64'(old_hi));
        issue(1'b0, 3'b001, 32'h20, $urandom, -1, 1'b0, 32'h0);

        w = 0;
        while (sb_q.size() > 0 && w < 200) begin @(negedge clk); w++; end
        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        repeat (3) @(negedge clk);
        mism = 0;
        for (int i = 0; i < 512; i++) if (dmem[i] !== ref_mem[i]) mism++;
        chk("memory_image", 64'(mism), 64'h0);
        chk("stray_mem_we", 64'(stray_we), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Parameters
REQ-001 SHALL provide parameter WIDTH, default 32: data and address width.

Interface
REQ-002 SHALL have one clock and a synchronous, active-low reset:
- clk  input  1  clock.
- rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have the following request ports:
- req_valid  input  1  pipeline request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_mode  input  3  access mode: 001 word, 010 half, 011 byte, 100 unsigned half, 101 unsigned byte.
- req_addr  input  WIDTH  byte address.
- req_wdata  input  WIDTH  store data.
REQ-004 SHALL have the following response ports:
- rsp_valid  output  1  single-cycle response pulse.
- rsp_rdata  output  WIDTH  extended load data, 0 for stores.
- rsp_err  output  1  illegal mode; valid with rsp_valid.
REQ-005 SHALL have the following memory-side ports:
- mem_addr  output  WIDTH  byte address to data memory.
- mem_wd  output  WIDTH  write data to data memory.
- mem_we  output  1  memory write enable.
- mem_mode  output  3  mode to data memory.
- mem_rd  input  WIDTH  combinational read data from data memory.

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS and RESP; req_ready = 1 only in IDLE.
REQ-007 SHALL, on a handshake (req_valid & req_ready at clk), capture addr, wdata, we and mode, clear beat counter, and go to ACCESS.
REQ-008 SHALL set beat count N = 4 for word, 2 for half, 1 for byte; a request with an illegal mode (000, 110, 111) SHALL go directly to RESP with rsp_err = 1 and no memory access.
REQ-009 SHALL, during ACCESS beat k (k = 0..N-1), drive mem_addr = addr + k (32-bit wrap at 2^32), mem_mode = 011, mem_wd = {24'b0, wdata[8k+7:8k]} and mem_we = we.
REQ-010 SHALL, for loads, sample mem_rd[7:0] at the end of beat k into byte k of the load register (little-endian).
REQ-011 SHALL treat the MMIO window (addr[31:2] == 0x100 >> 2) as one beat: mem_addr = addr, mem_mode = 001, rsp_rdata = mem_rd unmodified.
REQ-012 SHALL, after the last beat, enter RESP for exactly one cycle with rsp_valid = 1, then return to IDLE; accept-to-rsp_valid latency is N+1 cycles (1 for errors).
REQ-013 SHALL produce rsp_rdata as sign-extended for modes 010/011, zero-extended for 100/101, the full word for 001, and 0 for stores.
REQ-014 SHALL hold mem_we = 0 and mem_wd = 0 outside ACCESS; no backpressure on responses.
REQ-015 SHALL ignore req_valid while not in IDLE; inputs captured at handshake are unaffected by later input changes.

Reset
REQ-016 SHALL, while rst_n = 0 at clk, enter IDLE, clear the beat counter and load register, and hold rsp_valid, rsp_err, mem_we and rsp_rdata at 0.
REQ-017 SHALL, on reset mid-ACCESS, abort at that edge; bytes already written remain, no response is issued, and mem_we is 0 from the next cycle.

Structure
REQ-018 SHALL place the mode encodings, MMIO_TRIGGER_ADDR = 32'h100 and the FSM state enum in shared package mem_pkg.
REQ-019 SHALL implement sign/zero extension in combinational sub-module load_extend (inputs mode, raw word; output extended word).

Verification
REQ-020 SHALL cover a store word at 0x10 with wdata 0xA1B2C3D4: 4 beats write 0xD4, 0xC3, 0xB2, 0xA1 to 0x10..0x13, and rsp_valid occurs 5 cycles after accept.
REQ-021 SHALL cover a load half at 0x12 with memory bytes 0x34 at 0x12 and 0x85 at 0x13: rsp_rdata = 0xFFFF8534; with mode 100, rsp_rdata = 0x00008534.
REQ-022 SHALL cover a load byte at 0xFFFFFFFF followed by a load word at 0xFFFFFFFE: beat addresses wrap to 0x0 and 0x1, with no X values.
REQ-023 SHALL cover a load at 0x100 with mem_rd = 0x00000001: a single beat with mem_mode 001, rsp_rdata = 0x1, and latency 2.
REQ-024 SHALL cover req_mode 111: rsp_valid and rsp_err assert the cycle after accept, and mem_we never asserts.
REQ-025 SHALL cover rst_n low during beat 2 of a store word: only bytes 0 and 1 are written, no rsp_valid, and req_ready = 1 after rst_n returns high.
